mux8_1_rr_arb: RTL and testbench

MUX8_1_RR_ARB -- requirements
Module: mux8_1_rr_arb

---
 rtl/mux8_1_rr_arb.sv | 67 ++++++
 tb/tb_mux8_1_rr_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_1_rr_arb.sv
// 8-to-1 round-robin merge into a single registered output slot.
// The pointer advances past each granted channel, so every requester is served within 8 transfers.
module mux8_1_rr_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [2:0]       r_out_sel;
    logic [2:0]       r_rr_ptr;

    logic             w_load_en;
    logic             w_grant_found;
    logic [2:0]       w_grant;
    logic             w_in_xfer;
    logic [7:0]       w_in_ready;

    assign w_load_en = !r_out_valid || out_ready;

    // First requester at or above the pointer wins; the 3-bit index wraps 7 -> 0 on its own.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!w_grant_found && in_valid[r_rr_ptr + 3'(i)]) begin
                w_grant_found = 1'b1;
                w_grant       = r_rr_ptr + 3'(i);
            end
        end
    end

    // rst_n gates the handshake so no channel sees a ready while the block is held in reset.
    assign w_in_xfer  = rst_n && w_load_en && w_grant_found;
    assign w_in_ready = w_in_xfer ? (8'd1 << w_grant) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 3'd0;
            r_rr_ptr    <= 3'd0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
            r_out_sel   <= w_grant;
            r_rr_ptr    <= w_grant + 3'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux8_1_rr_arb.sv
// Bench for mux8_1_rr_arb: directed scenarios with hand-computed values plus a
// scoreboard monitor that predicts every grant and checks each emitted word.
module tb_mux8_1_rr_arb;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } word_t;

    word_t      sbQ[$];
    logic       mValid;
    logic [2:0] mPtr;

    always #5 clk = ~clk;

    mux8_1_rr_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic r);
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] chanData(input logic [7:0] base);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = base + 8'(k);
        return d;
    endfunction

    // Scoreboard monitor: samples on the falling edge, predicts the grant from its own pointer.
    initial begin : monitor
        logic [15:0] dbl;
        logic        found;
        logic        loadEn;
        int          g;
        logic [7:0]  expRdy;
        word_t       w;
        mValid = 1'b0;
        mPtr   = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("mon_rst_out_valid", 64'(out_valid), 0);
                checkOutput("mon_rst_in_ready", 64'(in_ready), 0);
                sbQ.delete();
                mValid = 1'b0;
                mPtr   = 3'd0;
            end else begin
                checkOutput("mon_out_valid", 64'(out_valid), 64'(mValid));
                if (out_valid === 1'b1 && out_ready) begin
                    checkOutput("mon_sb_nonempty", 64'(sbQ.size() > 0), 1);
                    if (sbQ.size() > 0) begin
                        w = sbQ.pop_front();
                        checkOutput("mon_out_sel", 64'(out_sel), 64'(w.sel));
                        checkOutput("mon_out_data", 64'(out_data), 64'(w.data));
                    end
                end
                dbl   = {in_valid, in_valid} >> mPtr;
                found = 1'b0;
                g     = 0;
                for (int j = 7; j >= 0; j--) begin
                    if (dbl[j]) begin
                        found = 1'b1;
                        g     = (int'(mPtr) + j) % 8;
                    end
                end
                loadEn = !mValid || out_ready;
                expRdy = (loadEn && found) ? 8'(1 << g) : 8'h00;
                checkOutput("mon_in_ready", 64'(in_ready), 64'(expRdy));
                if (loadEn && found) begin
                    w.sel  = 3'(g);
                    w.data = in_data[g*8 +: 8];
                    sbQ.push_back(w);
                    mValid = 1'b1;
                    mPtr   = 3'(g + 1);
                end else if (out_ready) begin
                    mValid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] stallPat [4];
        stallPat[0] = 8'hFF;
        stallPat[1] = 8'h00;
        stallPat[2] = 8'hAA;
        stallPat[3] = 8'h55;

        // Held in reset with every channel requesting.
        rst_n   = 1'b0;
        in_data = chanData(8'h10);
        applyStimulus(8'hFF, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_out_valid", 64'(out_valid), 0);
            checkOutput("rst_in_ready", 64'(in_ready), 0);
        end
        nextCycle();
        rst_n = 1'b1;

        // All channels valid: grants rotate 0..7,0,1.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rr_sel", 64'(out_sel), 64'(i % 8));
            checkOutput("rr_data", 64'(out_data), 64'(8'h10 + 8'(i % 8)));
            checkOutput("rr_valid", 64'(out_valid), 1);
        end

        // Empty the slot; pointer sits at 3.
        nextCycle();
        applyStimulus(8'h00, 1'b1);
        nextCycle();
        nextCycle();

        // Single word on channel 5 drains after one cycle.
        applyStimulus(8'h20, 1'b1);
        @(negedge clk);
        checkOutput("drain_in_ready", 64'(in_ready), 64'h20);
        nextCycle();
        applyStimulus(8'h00, 1'b1);
        @(negedge clk);
        checkOutput("drain_valid_hi", 64'(out_valid), 1);
        checkOutput("drain_sel", 64'(out_sel), 5);
        checkOutput("drain_data", 64'(out_data), 64'h15);
        checkOutput("drain_idle_ready", 64'(in_ready), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("drain_valid_lo", 64'(out_valid), 0);
        checkOutput("drain_idle_ready2", 64'(in_ready), 0);

        // Pointer at 6 with channels 0 and 2 requesting: wrap to 0, then 2, pointer lands on 3.
        nextCycle();
        applyStimulus(8'h05, 1'b1);
        @(negedge clk);
        checkOutput("wrap_ready0", 64'(in_ready), 64'h01);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap_sel0", 64'(out_sel), 0);
        checkOutput("wrap_data0", 64'(out_data), 64'h10);
        checkOutput("wrap_ready2", 64'(in_ready), 64'h04);
        nextCycle();
        applyStimulus(8'hFF, 1'b1);
        @(negedge clk);
        checkOutput("wrap_sel2", 64'(out_sel), 2);
        checkOutput("wrap_ptr3_ready", 64'(in_ready), 64'h08);
        nextCycle();
        applyStimulus(8'h00, 1'b1);
        @(negedge clk);
        checkOutput("wrap_sel3", 64'(out_sel), 3);
        checkOutput("wrap_data3", 64'(out_data), 64'h13);

        // Stall with channel 3 held, in_valid toggling underneath.
        nextCycle();
        applyStimulus(8'h08, 1'b0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stallPat[i], 1'b0);
            @(negedge clk);
            checkOutput("stall_sel", 64'(out_sel), 3);
            checkOutput("stall_data", 64'(out_data), 64'h13);
            checkOutput("stall_valid", 64'(out_valid), 1);
            checkOutput("stall_in_ready", 64'(in_ready), 0);
            nextCycle();
        end
        applyStimulus(8'hFF, 1'b1);
        @(negedge clk);
        checkOutput("unstall_ready4", 64'(in_ready), 64'h10);
        nextCycle();
        @(negedge clk);
        checkOutput("unstall_sel4", 64'(out_sel), 4);
        checkOutput("unstall_data4", 64'(out_data), 64'h14);

        // Reset mid-stream discards the held word; next grant restarts at channel 0.
        nextCycle();
        applyStimulus(8'hFF, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 0);
        checkOutput("midrst_in_ready", 64'(in_ready), 0);
        checkOutput("midrst_sel", 64'(out_sel), 0);
        checkOutput("midrst_data", 64'(out_data), 0);
        repeat (2) @(negedge clk);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("postrst_sel", 64'(out_sel), 0);
        checkOutput("postrst_data", 64'(out_data), 64'h10);

        // Random traffic, checked entirely by the scoreboard monitor.
        for (int i = 0; i < 12000; i++) begin
            nextCycle();
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
        end

        nextCycle();
        applyStimulus(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("final_sb_empty", 64'(sbQ.size()), 0);
        checkOutput("final_out_valid", 64'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
